// File: rtl/v_pkg.sv
// v_pkg: shared vector-unit opcodes, funct3 codes and queue FSM state type
package v_pkg;
  localparam logic [6:0] OPC_RTYPE = 7'h57;
  localparam logic [6:0] OPC_LTYPE = 7'h07;
  localparam logic [6:0] OPC_STYPE = 7'h27;
  localparam logic [2:0] OP_SET = 3'b111;
  typedef enum logic {Q_RUN, Q_WAIT_CFG} vq_state_t;
endpackage

// File: rtl/v_instr_queue_if.sv
// v_instr_queue_if: valid/ready stream of a vector instruction with its scalar operands
interface v_instr_queue_if #(parameter int XLEN = 32);
  logic valid;
  logic ready;
  logic [31:0] instr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  modport master (output valid, instr, rs1_data, rs2_data, input ready);
  modport slave (input valid, instr, rs1_data, rs2_data, output ready);
endinterface

// File: rtl/v_fifo_ptr.sv
// v_fifo_ptr: circular-buffer pointer and occupancy tracking with flush
module v_fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // pointers wrap naturally; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/v_instr_queue.sv
// v_instr_queue: show-ahead vector instruction queue that stalls behind vsetvl(i) until cfg_done
module v_instr_queue
  import v_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  v_instr_queue_if.slave in_if,
  v_instr_queue_if.master out_if,
  input  logic cfg_done,
  output logic cfg_wait,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = 32 + 2 * XLEN;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic push;
  logic pop;
  logic is_cfg;
  vq_state_t state;
  vq_state_t state_n;
  assign in_if.ready = !full && !flush && !rst;
  assign out_if.valid = state == Q_RUN && !empty;
  assign push = in_if.valid && in_if.ready;
  assign pop = out_if.valid && out_if.ready && !flush;
  assign head = empty ? '0 : mem[rd_ptr];
  assign {out_if.instr, out_if.rs1_data, out_if.rs2_data} = head;
  assign is_cfg = out_if.instr[6:0] == OPC_RTYPE && out_if.instr[14:12] == OP_SET;
  assign cfg_wait = state == Q_WAIT_CFG;
  v_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(push),
    .pop(pop),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // entry storage: contents are not reset, the head mux hides them while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_if.instr, in_if.rs1_data, in_if.rs2_data};
  end
  // FSM state register
  always_ff @(posedge clk) begin
    state <= rst ? Q_RUN : state_n;
  end
  // dispatching a config instruction blocks the head until the CSR unit commits
  always_comb begin
    state_n = flush ? Q_RUN
            : (state == Q_RUN && pop && is_cfg) ? Q_WAIT_CFG
            : (state == Q_WAIT_CFG && cfg_done) ? Q_RUN
            : state;
  end
endmodule

// File: tb/tb_v_instr_queue.sv
// tb_v_instr_queue: directed scoreboard bench for v_instr_queue
module tb_v_instr_queue;
  import v_pkg::*;
  localparam logic [31:0] VADD = 32'h0200_8057;
  localparam logic [31:0] VSETVLI = 32'h0D70_7057;
  localparam logic [31:0] VLE32 = 32'h0200_E007;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0;
  logic cfg_done = 0;
  logic cfg_wait;
  logic [2:0] count;
  logic full;
  logic empty;
  int checks = 0;
  int errors = 0;
  logic [95:0] sb [$];
  v_instr_queue_if #(.XLEN(32)) in_if ();
  v_instr_queue_if #(.XLEN(32)) out_if ();
  v_instr_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_if(in_if),
    .out_if(out_if),
    .cfg_done(cfg_done),
    .cfg_wait(cfg_wait),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    in_if.valid = v;
    in_if.instr = i;
    in_if.rs1_data = a;
    in_if.rs2_data = b;
  endtask
  // scoreboard: record accepted pushes, compare each dispatched head, then clock
  task automatic cycle();
    @(negedge clk);
    if (rst || flush) sb.delete();
    else begin
      if (out_if.valid && out_if.ready) begin
        if (sb.size() == 0) chk("pop_unexpected", 96'(out_if.valid), 96'(0));
        else chk("pop_order", {out_if.instr, out_if.rs1_data, out_if.rs2_data}, sb.pop_front());
      end
      if (in_if.valid && in_if.ready) sb.push_back({in_if.instr, in_if.rs1_data, in_if.rs2_data});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0);
    out_if.ready = 0;
    cycle();
    cycle();
    chk("rst_in_ready", 96'(in_if.ready), 96'(0));
    chk("rst_count", 96'(count), 96'(0));
    chk("rst_empty", 96'({empty, full, cfg_wait, out_if.valid}), 96'(4'b1000));
    chk("rst_out", {out_if.instr, out_if.rs1_data, out_if.rs2_data}, 96'(0));
    rst = 0;
    #1;
    chk("in_ready_after_rst", 96'(in_if.ready), 96'(1));
    for (int i = 0; i < 4; i++) begin
      drive(1, VADD | (32'(i) << 7), 32'(i), 32'(i + 100));
      cycle();
    end
    chk("full_flags", 96'({full, empty, in_if.ready}), 96'(3'b100));
    chk("full_count", 96'(count), 96'(4));
    drive(1, VADD | 32'hF80, 32'h55, 32'h66);
    cycle();
    chk("fifth_rejected", 96'(count), 96'(4));
    drive(0, 0, 0, 0);
    out_if.ready = 1;
    for (int i = 0; i < 4; i++) cycle();
    chk("drained", 96'({empty, count}), 96'({1'b1, 3'd0}));
    chk("sb_drained", 96'(sb.size()), 96'(0));
    out_if.ready = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1, VADD | (32'(i) << 15), 32'(i + 200), 32'(i));
      cycle();
    end
    out_if.ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, VADD | (32'(i) << 20), 32'(i + 300), 32'(~i));
      cycle();
      chk("concurrent_count", 96'(count), 96'(2));
    end
    drive(0, 0, 0, 0);
    cycle();
    cycle();
    chk("concurrent_drained", 96'(sb.size()), 96'(0));
    out_if.ready = 0;
    cfg_done = 1;
    cycle();
    cfg_done = 0;
    chk("cfg_done_ignored_in_run", 96'(cfg_wait), 96'(0));
    drive(1, VSETVLI, 32'd16, 32'd0);
    cycle();
    drive(1, VLE32, 32'h1000, 32'd0);
    cycle();
    drive(0, 0, 0, 0);
    out_if.ready = 1;
    cycle();
    chk("cfg_wait_set", 96'({cfg_wait, out_if.valid, count}), 96'({1'b1, 1'b0, 3'd1}));
    cycle();
    chk("cfg_wait_holds", 96'({cfg_wait, out_if.valid}), 96'(2'b10));
    cfg_done = 1;
    #1;
    chk("no_present_before_cfg_edge", 96'(out_if.valid), 96'(0));
    cfg_done = 0;
    out_if.ready = 0;
    cfg_done = 1;
    cycle();
    cfg_done = 0;
    chk("vle_presented", 96'({out_if.valid, cfg_wait, out_if.instr}), 96'({2'b10, VLE32}));
    out_if.ready = 1;
    cycle();
    chk("after_vle", 96'(empty), 96'(1));
    out_if.ready = 0;
    drive(1, VSETVLI, 32'd8, 32'd0);
    cycle();
    out_if.ready = 1;
    drive(1, VADD, 32'd1, 32'd1);
    cycle();
    out_if.ready = 0;
    for (int i = 2; i < 5; i++) begin
      drive(1, VADD, 32'(i), 32'(i));
      cycle();
    end
    chk("full_in_wait", 96'({full, cfg_wait}), 96'(2'b11));
    flush = 1;
    drive(1, 32'hAAAA_AAAA, 32'd9, 32'd9);
    cycle();
    flush = 0;
    drive(0, 0, 0, 0);
    chk("flush_state", 96'({empty, cfg_wait, out_if.valid, count}), 96'({3'b100, 3'd0}));
    cycle();
    chk("flush_push_dropped", 96'(count), 96'(0));
    drive(1, VADD, 32'hDEAD_BEEF, 32'h4);
    #1;
    chk("present_before_edge", 96'(out_if.valid), 96'(0));
    cycle();
    drive(0, 0, 0, 0);
    chk("present_after_edge", 96'({out_if.valid, out_if.rs1_data, out_if.rs2_data}), {1'b1, 32'hDEAD_BEEF, 32'h4, 31'd0} >> 31);
    out_if.ready = 1;
    cycle();
    out_if.ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, VADD | (32'(i) << 7), 32'(i + 500), 32'(i));
      cycle();
    end
    drive(0, 0, 0, 0);
    chk("pre_rst_count", 96'(count), 96'(3));
    rst = 1;
    cycle();
    rst = 0;
    #1;
    chk("mid_rst_flags", 96'({out_if.valid, cfg_wait, empty, full, in_if.ready, count}), 96'({5'b00101, 3'd0}));
    chk("mid_rst_out", {out_if.instr, out_if.rs1_data, out_if.rs2_data}, 96'(0));
    drive(1, VADD | 32'h100, 32'h777, 32'h888);
    cycle();
    drive(0, 0, 0, 0);
    chk("no_stale_head", {out_if.instr, out_if.rs1_data, out_if.rs2_data}, {VADD | 32'h100, 32'h777, 32'h888});
    out_if.ready = 1;
    cycle();
    chk("final_empty", 96'({empty, count, out_if.valid}), 96'({1'b1, 3'd0, 1'b0}));
    chk("final_sb", 96'(sb.size()), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/v_instr_queue.md
# v_instr_queue

Vector instruction queue between the scalar core's vector-dispatch port and `v_decoder`. It buffers vector instructions together with the scalar operands captured at dispatch (rs1, rs2), and presents the oldest entry to the decoder and issue logic through a valid/ready handshake. It serialises `vsetvli`/`vsetvl` so that no later instruction leaves the queue before the new configuration is committed.

## Interface
- `DEPTH`, 4, number of entries; must be a power of two and at least 2.
- `XLEN`, 32, width of the scalar operands.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `flush`  in  1  synchronous discard of all entries and of any configuration wait.
- `in_valid`  in  1  scalar core offers a vector instruction.
- `in_ready`  out  1  queue accepts; equals `!full && !flush && !rst`.
- `in_instr`  in  32  raw instruction word.
- `in_rs1_data`  in  XLEN  rs1 value: AVL, scalar operand or base address.
- `in_rs2_data`  in  XLEN  rs2 value: vtype (vsetvl) or stride.
- `out_valid`  out  1  head entry is presented and dispatch is not blocked.
- `out_ready`  in  1  issue stage consumes the head entry.
- `out_instr`  out  32  head instruction, fed to `v_decoder.instr`.
- `out_rs1_data`, `out_rs2_data`  out  XLEN  head operands.
- `cfg_done`  in  1  single-cycle pulse: vector CSR unit has committed vl/vtype.
- `cfg_wait`  out  1  high while in WAIT_CFG.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `full`, `empty`  out  1  `count==DEPTH`, `count==0`.

## Operation
- Circular buffer with write pointer, read pointer and count. Pointers are $clog2(DEPTH) bits and wrap naturally.
- A push occurs when `in_valid && in_ready`.
- A pop occurs when `out_valid && out_ready`.
- Push and pop in the same cycle:
  - Count is unchanged; both pointers advance.
  - This is legal at any count below DEPTH.
  - When full, `in_ready` is low, so only the pop happens.
- Outputs are show-ahead: `out_instr` and `out_*_data` always carry the entry at the read pointer. They hold their values while `out_valid && !out_ready`.
- Config detection on the head entry: `is_cfg = out_instr[6:0]==OPC_RTYPE && out_instr[14:12]==OP_SET`.
- FSM states are RUN and WAIT_CFG.
  - RUN: `out_valid = !empty`.
  - RUN → WAIT_CFG: on a pop of a head entry with `is_cfg`.
  - WAIT_CFG: `out_valid = 0`; pushes are still accepted.
  - WAIT_CFG → RUN: on `cfg_done`.
  - `cfg_done` while in RUN is ignored.
- Flush:
  - Pointers and count go to 0 and the FSM goes to RUN.
  - A push or pop in the same cycle is dropped.
  - `cfg_done` in the flush cycle is ignored.
- Reset values:
  - count=0, pointers=0, state=RUN.
  - `out_valid=0`, `in_ready=0` while `rst` is high, `cfg_wait=0`, `empty=1`, `full=0`.
  - `out_instr` and data outputs are 0.
  - Storage contents need not reset, but `out_*` must read 0 while empty.

## Timing
- Enqueue-to-present latency is 1 cycle. An instruction pushed into an empty queue at edge N has `out_valid=1` after edge N.
- There is no bypass: a push never appears on the outputs in the same cycle it is accepted.
- `in_ready` depends only on registered state, `flush` and `rst`. It has no combinational path from `out_ready`.
- `out_valid` depends only on registered state. It has no combinational path from `in_valid`.
- WAIT_CFG exit:
  - `cfg_done` at edge M returns the FSM to RUN.
  - The next head is presented with `out_valid=1` after edge M.
  - The minimum gap between config dispatch and the next dispatch is 2 cycles.
- Throughput is 1 instruction per cycle sustained when no config instruction is present.
- Reset asserted mid-operation: all contents are lost at the next edge. No partial entries survive.

## Structure
- The shared package `v_pkg` holds `OPC_RTYPE`, `OPC_LTYPE`, `OPC_STYPE` and `OP_SET`, and gains `typedef enum logic {Q_RUN, Q_WAIT_CFG} vq_state_t`.
- The queue does no other decoding; all decode remains in `v_decoder`.
- Storage is a single entry array of {instr, rs1, rs2}, 32+2·XLEN bits, inside this module. No sub-module is needed.
- Optional sub-module: `v_fifo_ptr`, for the pointer/count logic, if it is reused by the LSU queues.

## Test plan
- Reset, then push 4 `vadd.vv` words (0x02008057…) with `out_ready=0`:
  - `full=1`, `in_ready=0`, `count=4`.
  - A 5th `in_valid` is not accepted.
  - Popping afterwards yields the words in FIFO order.
- Concurrent push and pop at count=2 for 10 cycles with `out_ready=1`:
  - `count` stays at 2.
  - Ordering is preserved across pointer wrap.
- Push `vsetvli` (0x0D707057, rs1=16), then `vle32`:
  - After `vsetvli` is popped, `cfg_wait=1` and `out_valid=0`, even with `count=1`.
  - `cfg_done` pulse → `vle32` is presented the next cycle.
- `flush` asserted while full and in WAIT_CFG, with `in_valid=1` in the same cycle:
  - Next cycle: `count=0`, `empty=1`, `cfg_wait=0`.
  - The pushed word is dropped.
- Push into empty queue at edge N:
  - `out_valid=0` before N and 1 after N.
  - `out_rs1_data` and `out_rs2_data` match the pushed values, e.g. 0xDEADBEEF and 0x4.
- `rst` asserted for one cycle mid-stream with `count=3`:
  - Next cycle: all outputs are at their reset values.
  - Stale entries never reappear.
